ex_wb_stage: RTL and testbench

EX_WB_STAGE -- requirements
Module: ex_wb_stage

---
 rtl/ex_wb_stage.sv | 150 +++++++++++++++
 tb/tb_ex_wb_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_wb_stage.sv
// ex_wb_stage: write-back buffer between the execute stage and the register file.
//
// Execute results are decoded into {addr, data, byte_en} and held in a 2-entry
// in-order FIFO. The head entry drives the register-file write port. There is
// always one cycle of latency: an accept into an empty FIFO does not bypass it.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   ex_valid/ex_ready   execute-side handshake (ex_ready depends on state only)
//   ex_result [0:63]    result word, bit 0 is the MSB
//   ex_rd, ex_ppp       destination address and byte-participation field
//   ex_wren             instruction writes the register file
//   rf_wr_en/rf_ready   register-file write handshake
//   rf_wr_addr/data     head entry address and data
//   rf_byte_en [0:7]    head entry byte enables, bit k covers data bits [8k:8k+7]
//   wb_count            occupied entries (0..2)
//
// Optional build macro EX_WB_FWD_EN adds a combinational forwarding lookup:
//   fwd_addr in; fwd_hit, fwd_data, fwd_byte_en out (all zero on a miss).
module ex_wb_stage #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [0:63]       ex_result,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic [2:0]        ex_ppp,
    input  logic              ex_wren,
    output logic              rf_wr_en,
    input  logic              rf_ready,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [0:63]       rf_wr_data,
    output logic [0:7]        rf_byte_en,
    output logic [1:0]        wb_count
`ifdef EX_WB_FWD_EN
    ,
    input  logic [ADDR_W-1:0] fwd_addr,
    output logic              fwd_hit,
    output logic [0:63]       fwd_data,
    output logic [0:7]        fwd_byte_en
`endif
);

    logic [ADDR_W-1:0] addr_q [2];
    logic [ADDR_W-1:0] addr_d [2];
    logic [0:63]       data_q [2];
    logic [0:63]       data_d [2];
    logic [0:7]        be_q   [2];
    logic [0:7]        be_d   [2];
    logic              wptr_q, wptr_d;
    logic              rptr_q, rptr_d;
    logic [1:0]        count_q, count_d;

    logic [0:7] dec_be;
    logic       push;
    logic       pop;

    // Leftmost literal bit is byte 0 (the most significant byte of the result).
    always_comb begin
        dec_be = 8'b0000_0000;
        case (ex_ppp)
            3'b000:  dec_be = 8'b1111_1111;
            3'b001:  dec_be = 8'b1111_0000;
            3'b010:  dec_be = 8'b0000_1111;
            3'b011:  dec_be = 8'b1010_1010;
            3'b100:  dec_be = 8'b0101_0101;
            default: dec_be = 8'b0000_0000;
        endcase
    end

    assign ex_ready = (count_q != 2'd2);
    assign rf_wr_en = (count_q != 2'd0);

    // Transfers that do not write anything are accepted and dropped.
    assign push = ex_valid && ex_ready && ex_wren && (dec_be != 8'b0000_0000);
    assign pop  = rf_wr_en && rf_ready;

    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        be_d    = be_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            addr_d[wptr_q] = ex_rd;
            data_d[wptr_q] = ex_result;
            be_d[wptr_q]   = dec_be;
            wptr_d         = ~wptr_q;
        end
        if (pop) begin
            rptr_d = ~rptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            be_q    <= be_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Outputs are zeroed while empty so stale popped entries never show.
    assign rf_wr_addr = rf_wr_en ? addr_q[rptr_q] : '0;
    assign rf_wr_data = rf_wr_en ? data_q[rptr_q] : '0;
    assign rf_byte_en = rf_wr_en ? be_q[rptr_q]   : '0;
    assign wb_count   = count_q;

`ifdef EX_WB_FWD_EN
    // Youngest entry sits just behind the write pointer; the older one is the head.
    logic yng_idx;
    assign yng_idx = ~wptr_q;

    always_comb begin
        fwd_hit     = 1'b0;
        fwd_data    = '0;
        fwd_byte_en = '0;
        if ((count_q != 2'd0) && (addr_q[yng_idx] == fwd_addr)) begin
            fwd_hit     = 1'b1;
            fwd_data    = data_q[yng_idx];
            fwd_byte_en = be_q[yng_idx];
        end else if ((count_q == 2'd2) && (addr_q[rptr_q] == fwd_addr)) begin
            fwd_hit     = 1'b1;
            fwd_data    = data_q[rptr_q];
            fwd_byte_en = be_q[rptr_q];
        end
    end
`endif

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed self-checking bench for ex_wb_stage.
module tb_ex_wb_stage;

    logic        clk;
    logic        reset_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [0:63] ex_result;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_ppp;
    logic        ex_wren;
    logic        rf_wr_en;
    logic        rf_ready;
    logic [4:0]  rf_wr_addr;
    logic [0:63] rf_wr_data;
    logic [0:7]  rf_byte_en;
    logic [1:0]  wb_count;
`ifdef EX_WB_FWD_EN
    logic [4:0]  fwd_addr;
    logic        fwd_hit;
    logic [0:63] fwd_data;
    logic [0:7]  fwd_byte_en;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    ex_wb_stage #(.ADDR_W(5)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_result  (ex_result),
        .ex_rd      (ex_rd),
        .ex_ppp     (ex_ppp),
        .ex_wren    (ex_wren),
        .rf_wr_en   (rf_wr_en),
        .rf_ready   (rf_ready),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .rf_byte_en (rf_byte_en),
        .wb_count   (wb_count)
`ifdef EX_WB_FWD_EN
        ,
        .fwd_addr   (fwd_addr),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data),
        .fwd_byte_en(fwd_byte_en)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_ex(input logic v, input logic w, input logic [4:0] rd,
                          input logic [2:0] ppp, input logic [63:0] d);
        ex_valid  = v;
        ex_wren   = w;
        ex_rd     = rd;
        ex_ppp    = ppp;
        ex_result = d;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n  = 1'b0;
        rf_ready = 1'b0;
        set_ex(1'b0, 1'b0, 5'd0, 3'd0, 64'd0);
`ifdef EX_WB_FWD_EN
        fwd_addr = 5'd0;
`endif
        // Reset values
        #2;
        check("rst_count", 64'(wb_count), 64'd0);
        check("rst_wr_en", 64'(rf_wr_en), 64'd0);
        check("rst_ready", 64'(ex_ready), 64'd1);
        check("rst_data",  64'(rf_wr_data), 64'd0);
        step();
        step();
        reset_n = 1'b1;

        // First push, one-cycle latency, no bypass
        set_ex(1'b1, 1'b1, 5'd3, 3'b000, 64'h0123456789ABCDEF);
        #1;
        check("nobypass_wr_en", 64'(rf_wr_en), 64'd0);
        step();
        set_ex(1'b0, 1'b0, 5'd0, 3'd0, 64'd0);
        check("p1_wr_en", 64'(rf_wr_en), 64'd1);
        check("p1_addr",  64'(rf_wr_addr), 64'd3);
        check("p1_be",    64'(rf_byte_en), 64'hFF);
        check("p1_data",  64'(rf_wr_data), 64'h0123456789ABCDEF);
        check("p1_count", 64'(wb_count), 64'd1);
        rf_ready = 1'b1;
        step();
        check("p1_drain", 64'(wb_count), 64'd0);

        // PPP decode; second push coincides with pop of first at count 1
        set_ex(1'b1, 1'b1, 5'd7, 3'b011, 64'h1111_2222_3333_4444);
        step();
        check("ppp011_addr", 64'(rf_wr_addr), 64'd7);
        check("ppp011_be",   64'(rf_byte_en), 64'hAA);
        set_ex(1'b1, 1'b1, 5'd8, 3'b100, 64'h5555_6666_7777_8888);
        step();
        set_ex(1'b0, 1'b0, 5'd0, 3'd0, 64'd0);
        check("ppp100_count", 64'(wb_count), 64'd1);
        check("ppp100_addr",  64'(rf_wr_addr), 64'd8);
        check("ppp100_be",    64'(rf_byte_en), 64'h55);
        check("ppp100_data",  64'(rf_wr_data), 64'h5555_6666_7777_8888);
        step();
        check("ppp_drain", 64'(wb_count), 64'd0);

        // Back-pressure
        rf_ready = 1'b0;
        set_ex(1'b1, 1'b1, 5'd10, 3'b000, 64'hA0A0);
        step();
        check("bp1_ready", 64'(ex_ready), 64'd1);
        set_ex(1'b1, 1'b1, 5'd11, 3'b000, 64'hB1B1);
        step();
        check("bp2_count", 64'(wb_count), 64'd2);
        check("bp2_ready", 64'(ex_ready), 64'd0);
        set_ex(1'b1, 1'b1, 5'd12, 3'b010, 64'hC2C2);
        step();
        check("bp3_count", 64'(wb_count), 64'd2);
        check("bp3_addr",  64'(rf_wr_addr), 64'd10);
        check("bp3_data",  64'(rf_wr_data), 64'hA0A0);
        rf_ready = 1'b1;
        step();
        check("bpd1_ready", 64'(ex_ready), 64'd1);
        check("bpd1_addr",  64'(rf_wr_addr), 64'd11);
        check("bpd1_count", 64'(wb_count), 64'd1);
        step();
        set_ex(1'b0, 1'b0, 5'd0, 3'd0, 64'd0);
        check("bpd2_addr",  64'(rf_wr_addr), 64'd12);
        check("bpd2_be",    64'(rf_byte_en), 64'h0F);
        check("bpd2_count", 64'(wb_count), 64'd1);
        step();
        check("bpd3_count", 64'(wb_count), 64'd0);

        // Discards
        rf_ready = 1'b0;
        set_ex(1'b1, 1'b0, 5'd1, 3'b000, 64'h1);
        step();
        check("dis_wren0", 64'(wb_count), 64'd0);
        set_ex(1'b1, 1'b1, 5'd2, 3'b110, 64'h2);
        step();
        check("dis_ppp110", 64'(wb_count), 64'd0);
        set_ex(1'b1, 1'b1, 5'd5, 3'b001, 64'h5);
        step();
        set_ex(1'b0, 1'b0, 5'd0, 3'd0, 64'd0);
        check("dis_count", 64'(wb_count), 64'd1);
        check("dis_addr",  64'(rf_wr_addr), 64'd5);
        check("dis_be",    64'(rf_byte_en), 64'hF0);
        rf_ready = 1'b1;
        step();
        check("dis_drain", 64'(wb_count), 64'd0);

        // Mid-operation asynchronous reset
        rf_ready = 1'b0;
        set_ex(1'b1, 1'b1, 5'd20, 3'b000, 64'h20);
        step();
        set_ex(1'b1, 1'b1, 5'd21, 3'b000, 64'h21);
        step();
        set_ex(1'b0, 1'b0, 5'd0, 3'd0, 64'd0);
        check("mr_full", 64'(wb_count), 64'd2);
        reset_n = 1'b0;
        #1;
        check("mr_wr_en", 64'(rf_wr_en), 64'd0);
        check("mr_count", 64'(wb_count), 64'd0);
        check("mr_ready", 64'(ex_ready), 64'd1);
        #1;
        reset_n  = 1'b1;
        rf_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mr_nowrite", 64'(rf_wr_en), 64'd0);
        end

`ifdef EX_WB_FWD_EN
        // Forwarding picks the youngest matching entry
        rf_ready = 1'b0;
        set_ex(1'b1, 1'b1, 5'd4, 3'b000, 64'hAAAA_0000_AAAA_0000);
        step();
        set_ex(1'b1, 1'b1, 5'd4, 3'b010, 64'hBBBB_0000_BBBB_0000);
        step();
        set_ex(1'b0, 1'b0, 5'd0, 3'd0, 64'd0);
        fwd_addr = 5'd4;
        #1;
        check("fwd_hit",  64'(fwd_hit), 64'd1);
        check("fwd_data", 64'(fwd_data), 64'hBBBB_0000_BBBB_0000);
        check("fwd_be",   64'(fwd_byte_en), 64'h0F);
        fwd_addr = 5'd9;
        #1;
        check("fwd_miss_hit",  64'(fwd_hit), 64'd0);
        check("fwd_miss_data", 64'(fwd_data), 64'd0);
        rf_ready = 1'b1;
        step();
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
